// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared types for the button event generator: the event codes that appear on
//   the event port and the states of the press/hold tracking FSM, plus the
//   request record the FSM hands to the event register.
// -----------------------------------------------------------------------------
package button_pkg;

   // Encoding is visible on evt_code, so values are pinned explicitly.
   typedef enum logic [1:0] {
      EVT_PRESS   = 2'd0,
      EVT_RELEASE = 2'd1,
      EVT_LONG    = 2'd2,
      EVT_REPEAT  = 2'd3
   } btn_evt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_HELD
   } btn_state_t;

   // One-cycle event request from the FSM to the event register.
   typedef struct packed {
      logic     fire;
      btn_evt_t code;
   } evt_req_t;

endpackage

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//   Normalises button polarity, synchronises the raw pin into the Clk domain
//   and accepts a new level only after it has been seen for STABLE_CYCLES
//   consecutive synchronised samples.
//
// Ports
//   Clk    in   system clock
//   reset  in   synchronous, active-high reset
//   in     in   raw asynchronous button pin
//   level  out  debounced state, 1 = pressed
// -----------------------------------------------------------------------------
module debounce_filter #(
   parameter int unsigned STABLE_CYCLES = 480_000,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned CNT_WIDTH     = 26
) (
   input  logic Clk,
   input  logic reset,
   input  logic in,
   output logic level
);

   localparam logic [CNT_WIDTH-1:0] STAB_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic                 pressed_raw;
   logic [1:0]           sync;
   logic                 s;
   logic [CNT_WIDTH-1:0] stab_cnt;

   // After this, 1 always means "pressed", whatever the board wiring.
   assign pressed_raw = ACTIVE_LOW ? ~in : in;
   assign s           = sync[1];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value; blocking here would collapse the two-stage
   // synchroniser into a single stage.
   always_ff @(posedge Clk) begin
      if (reset) begin
         sync     <= 2'b00;   // not-pressed after polarity normalisation
         stab_cnt <= '0;
         level    <= 1'b0;
      end else begin
         sync <= {sync[0], pressed_raw};
         if (s == level) begin
            stab_cnt <= '0;
         end else if (stab_cnt == STAB_LAST) begin
            // Disagreement has lasted STABLE_CYCLES samples: accept it.
            level    <= s;
            stab_cnt <= '0;
         end else begin
            stab_cnt <= stab_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//   Debounced push-button to event stream: PRESS, RELEASE, LONG (held past
//   LONG_CYCLES) and REPEAT (every REPEAT_CYCLES after LONG). Events leave
//   through a single-entry valid/ready port; an event arriving while the port
//   is full and not being drained is dropped and flagged in sticky overflow.
//
// Ports
//   Clk             in   system clock, the only clock
//   reset           in   synchronous, active-high reset
//   btn_in          in   raw asynchronous button pin
//   level           out  debounced button state, 1 = pressed
//   evt_valid       out  event pending
//   evt_ready       in   consumer takes the event this cycle when evt_valid=1
//   evt_code        out  0=PRESS 1=RELEASE 2=LONG 3=REPEAT, stable while valid
//   overflow        out  sticky: an event was dropped
//   clear_overflow  in   clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module button_event_gen
   import button_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 480_000,
   parameter int unsigned LONG_CYCLES   = 48_000_000,
   parameter int unsigned REPEAT_CYCLES = 9_600_000,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned CNT_WIDTH     = 26
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       btn_in,
   output logic       level,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [1:0] evt_code,
   output logic       overflow,
   input  logic       clear_overflow
);

   localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

   btn_state_t           state;
   btn_state_t           state_next;
   logic [CNT_WIDTH-1:0] hold_cnt;
   logic                 hold_clear;
   evt_req_t             req;
   btn_evt_t             evt_code_q;
   logic                 drop;

   debounce_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .CNT_WIDTH     (CNT_WIDTH)
   ) u_debounce (
      .Clk   (Clk),
      .reset (reset),
      .in    (btn_in),
      .level (level)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge Clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_clear ? '0 : hold_cnt + 1'b1;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: every always_comb output gets a default before the case so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (level) state_next = ST_PRESSED;
         ST_PRESSED: begin
            if (!level)                     state_next = ST_IDLE;
            else if (hold_cnt == LONG_LAST) state_next = ST_HELD;
         end
         ST_HELD:    if (!level) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Release is tested first so it wins over a same-cycle LONG/REPEAT.
   always_comb begin
      req.fire   = 1'b0;
      req.code   = EVT_PRESS;
      hold_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            hold_clear = 1'b1;
            if (level) begin
               req.fire = 1'b1;
               req.code = EVT_PRESS;
            end
         end
         ST_PRESSED: begin
            if (!level) begin
               req.fire   = 1'b1;
               req.code   = EVT_RELEASE;
               hold_clear = 1'b1;
            end else if (hold_cnt == LONG_LAST) begin
               req.fire   = 1'b1;
               req.code   = EVT_LONG;
               hold_clear = 1'b1;
            end
         end
         ST_HELD: begin
            if (!level) begin
               req.fire   = 1'b1;
               req.code   = EVT_RELEASE;
               hold_clear = 1'b1;
            end else if (hold_cnt == REPEAT_LAST) begin
               req.fire   = 1'b1;
               req.code   = EVT_REPEAT;
               hold_clear = 1'b1;
            end
         end
         default: hold_clear = 1'b1;
      endcase
   end

   // ------------------------------------------------------------- event port
   // The slot can take a new event when empty or when it is drained this cycle.
   assign drop = req.fire && evt_valid && !evt_ready;

   always_ff @(posedge Clk) begin
      if (reset) begin
         evt_valid  <= 1'b0;
         evt_code_q <= EVT_PRESS;
         overflow   <= 1'b0;
      end else begin
         if (req.fire) begin
            if (!evt_valid || evt_ready) begin
               evt_valid  <= 1'b1;
               evt_code_q <= req.code;
            end
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end

         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   assign evt_code = evt_code_q;

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// tb_button_event_gen
//   Directed bench for button_event_gen with STABLE=4, LONG=20, REPEAT=8,
//   active-low pin. A vector table covers basic press/release and a rejected
//   glitch; hand-written sequences cover long/repeat timing, overflow,
//   accept-and-reload on a full port, and reset in the middle of a hold.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

   localparam int unsigned STABLE = 4;
   localparam int unsigned LONG   = 20;
   localparam int unsigned REPEAT = 8;

   localparam logic [1:0] C_PRESS   = 2'd0;
   localparam logic [1:0] C_RELEASE = 2'd1;
   localparam logic [1:0] C_LONG    = 2'd2;
   localparam logic [1:0] C_REPEAT  = 2'd3;

   logic       clk;
   logic       reset;
   logic       btn_in;
   logic       level;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_code;
   logic       overflow;
   logic       clear_overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   button_event_gen #(
      .STABLE_CYCLES (STABLE),
      .LONG_CYCLES   (LONG),
      .REPEAT_CYCLES (REPEAT),
      .ACTIVE_LOW    (1'b1),
      .CNT_WIDTH     (8)
   ) dut (
      .Clk            (clk),
      .reset          (reset),
      .btn_in         (btn_in),
      .level          (level),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_code       (evt_code),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       btn;
      logic       ready;
      logic       clr;
      int         cycles;
      logic       lvl;
      logic       vld;
      logic [1:0] code;
      logic       ovf;
   } vec_t;

   vec_t vecs [11];

   // Advance n clock edges; outputs are then sampled 1 time unit after the edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic lvl, input logic vld,
                            input logic [1:0] code, input logic ovf);
      check({tag, ".level"},     32'(level),     32'(lvl));
      check({tag, ".evt_valid"}, 32'(evt_valid), 32'(vld));
      check({tag, ".evt_code"},  32'(evt_code),  32'(code));
      check({tag, ".overflow"},  32'(overflow),  32'(ovf));
   endtask

   // Expected event at cycle offset i of the 60-cycle hold sequence.
   function automatic bit hold_evt(input int i, output logic [1:0] code);
      code = C_PRESS;
      case (i)
         7:              begin code = C_PRESS;   return 1'b1; end
         27:             begin code = C_LONG;    return 1'b1; end
         35, 43, 51, 59: begin code = C_REPEAT;  return 1'b1; end
         67:             begin code = C_RELEASE; return 1'b1; end
         default:        return 1'b0;
      endcase
   endfunction

   initial begin
      logic [1:0] exp_code;
      bit         exp_v;

      // btn, ready, clr, cycles -> level, valid, code, overflow
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, C_PRESS,   1'b0};  // edge+5: not yet
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, C_PRESS,   1'b0};  // edge+6: level
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, C_PRESS,   1'b0};  // PRESS
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, C_PRESS,   1'b0};  // consumed
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0, C_PRESS,   1'b0};  // release edge+5
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, C_PRESS,   1'b0};  // level drops
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, C_RELEASE, 1'b0};  // RELEASE
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, C_RELEASE, 1'b0};  // consumed
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, C_RELEASE, 1'b0};  // 3-cycle glitch
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, C_RELEASE, 1'b0};  // counter at 3, no accept
      vecs[10] = '{1'b1, 1'b1, 1'b0, 6, 1'b0, 1'b0, C_RELEASE, 1'b0};  // settled, no event

      reset          = 1'b1;
      btn_in         = 1'b1;
      evt_ready      = 1'b1;
      clear_overflow = 1'b0;
      tick(2);
      check_all("reset", 1'b0, 1'b0, C_PRESS, 1'b0);
      reset = 1'b0;

      // ---- table: basic press/release and rejected glitch
      for (int v = 0; v < 11; v++) begin
         btn_in         = vecs[v].btn;
         evt_ready      = vecs[v].ready;
         clear_overflow = vecs[v].clr;
         tick(vecs[v].cycles);
         check_all($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].vld, vecs[v].code, vecs[v].ovf);
      end

      // ---- long hold: PRESS, LONG, REPEATs, RELEASE beating a same-cycle REPEAT
      btn_in = 1'b0;
      for (int i = 1; i <= 72; i++) begin
         tick(1);
         if (i == 60) btn_in = 1'b1;
         exp_v = hold_evt(i, exp_code);
         check($sformatf("hold.level[%0d]", i), 32'(level), 32'((i >= 6 && i < 66) ? 1 : 0));
         check($sformatf("hold.valid[%0d]", i), 32'(evt_valid), 32'(exp_v));
         if (exp_v) check($sformatf("hold.code[%0d]", i), 32'(evt_code), 32'(exp_code));
      end
      check("hold.overflow", 32'(overflow), 32'(0));

      // ---- overflow: PRESS held, RELEASE dropped
      evt_ready = 1'b0;
      btn_in    = 1'b0;
      tick(7);
      check_all("ovf.press", 1'b1, 1'b1, C_PRESS, 1'b0);
      btn_in = 1'b1;
      tick(7);
      check_all("ovf.drop", 1'b0, 1'b1, C_PRESS, 1'b1);
      clear_overflow = 1'b1;
      tick(1);
      check_all("ovf.clear", 1'b0, 1'b1, C_PRESS, 1'b0);
      clear_overflow = 1'b0;
      // second PRESS dropped in the same cycle as a clear request
      btn_in = 1'b0;
      tick(6);
      clear_overflow = 1'b1;
      tick(1);
      check_all("ovf.set_wins", 1'b1, 1'b1, C_PRESS, 1'b1);
      clear_overflow = 1'b0;
      evt_ready      = 1'b1;
      btn_in         = 1'b1;
      tick(1);
      check_all("ovf.drain", 1'b1, 1'b0, C_PRESS, 1'b1);
      tick(6);
      check_all("ovf.release", 1'b0, 1'b1, C_RELEASE, 1'b1);
      clear_overflow = 1'b1;
      tick(1);
      check_all("ovf.clear2", 1'b0, 1'b0, C_RELEASE, 1'b0);
      clear_overflow = 1'b0;

      // ---- accept and reload in one cycle: LONG pending, REPEAT arrives with ready
      btn_in = 1'b0;
      tick(7);
      check_all("reload.press", 1'b1, 1'b1, C_PRESS, 1'b0);
      tick(1);
      check_all("reload.drain", 1'b1, 1'b0, C_PRESS, 1'b0);
      evt_ready = 1'b0;
      tick(19);
      check_all("reload.long", 1'b1, 1'b1, C_LONG, 1'b0);
      tick(7);
      check_all("reload.long_held", 1'b1, 1'b1, C_LONG, 1'b0);
      evt_ready = 1'b1;
      tick(1);
      check_all("reload.repeat", 1'b1, 1'b1, C_REPEAT, 1'b0);
      tick(1);
      check_all("reload.empty", 1'b1, 1'b0, C_REPEAT, 1'b0);

      // ---- reset mid-HELD with a pending event and overflow set
      evt_ready = 1'b0;
      tick(7);
      check_all("rst.repeat", 1'b1, 1'b1, C_REPEAT, 1'b0);
      tick(8);
      check_all("rst.drop", 1'b1, 1'b1, C_REPEAT, 1'b1);
      reset = 1'b1;
      tick(1);
      check_all("rst.cleared", 1'b0, 1'b0, C_PRESS, 1'b0);
      reset     = 1'b0;
      evt_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check($sformatf("rst.level[%0d]", i), 32'(level), 32'((i == 6) ? 1 : 0));
         check($sformatf("rst.no_evt[%0d]", i), 32'(evt_valid), 32'(0));
      end
      tick(1);
      check_all("rst.press", 1'b1, 1'b1, C_PRESS, 1'b0);
      tick(1);
      check_all("rst.press_taken", 1'b1, 1'b0, C_PRESS, 1'b0);
      btn_in = 1'b1;
      tick(7);
      check_all("rst.release", 1'b0, 1'b1, C_RELEASE, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
